feedback_arbiter: RTL and testbench

//  Shares the LED/speaker feedback path (num + pressed into numToLed, numToFrequency, Speaker)

---
 rtl/simon_pkg.sv | 32 +++
 rtl/feedback_arbiter_tone_timer.sv | 28 ++
 rtl/feedback_arbiter.sv | 157 +++++++++++++++
 tb/tb_feedback_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon feedback path arbiter.
package simon_pkg;

  // Who currently drives the LED/speaker feedback path
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_SIMON  = 2'd1,
    OWN_PLAYER = 2'd2,
    OWN_ALARM  = 2'd3
  } owner_t;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GAP   = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  // Tone/LED index used for the steady alarm and as the first melody note
  localparam logic [1:0] ALARM_NUM = 2'd3;

  // Largest of three timing parameters, used to size the shared timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/feedback_arbiter_tone_timer.sv
// Loadable down-counter shared by tone hold, gap and alarm-note timing.
// done is high during the last cycle of an interval of 'value' cycles.
module tone_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count_reg;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg <= W'(1));

endmodule

// File: rtl/feedback_arbiter.sv
// Fixed-priority owner of the LED/speaker feedback path (alarm > player > simon).
// Enforces a minimum tone length and a silent gap between tones.
// Optional feature: define ALARM_MELODY_EN to cycle the alarm through notes 3,2,1,0.
module feedback_arbiter
  import simon_pkg::*;
#(
  parameter int MIN_HOLD_CYC = 1_000_000,
  parameter int GAP_CYC      = 250_000,
  parameter int NOTE_CYC     = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       simon_req,
  input  logic [1:0] simon_num,
  input  logic       player_req,
  input  logic [1:0] player_num,
  input  logic       game_over,
  output logic [1:0] num,
  output logic       pressed,
  output logic [1:0] owner
);

  localparam int CNT_W = $clog2(max3(MIN_HOLD_CYC, GAP_CYC, NOTE_CYC) + 1);

  state_t           state_reg, state_next;
  logic [1:0]       num_reg, num_next;
  logic             pressed_reg, pressed_next;
  owner_t           owner_reg, owner_next;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;
  logic             hold_req;
  logic [1:0]       hold_num;
  logic             note_adv;
  logic [1:0]       alarm_num;

  // Request and index of whoever owns the current tone
  assign hold_req = (owner_reg == OWN_PLAYER) ? player_req : simon_req;
  assign hold_num = (owner_reg == OWN_PLAYER) ? player_num : simon_num;

`ifdef ALARM_MELODY_EN
  logic [1:0] note_reg, note_next;

  assign note_adv = (state_reg == ST_ALARM) && (state_next == ST_ALARM) && timer_done;

  // Melody note: restart at 3 on alarm entry, step down when a note ends
  always_comb begin
    note_next = note_reg;
    if (state_reg != ST_ALARM) begin
      note_next = ALARM_NUM;
    end else if (note_adv) begin
      note_next = note_reg - 2'd1;
    end
  end

  // Melody note register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_reg <= ALARM_NUM;
    end else begin
      note_reg <= note_next;
    end
  end

  assign alarm_num = note_next;
`else
  assign note_adv  = 1'b0;
  assign alarm_num = ALARM_NUM;
`endif

  // Next-state logic; game_over preempts everything, including the gap
  always_comb begin
    state_next = state_reg;
    if (game_over) begin
      state_next = ST_ALARM;
    end else begin
      case (state_reg)
        ST_IDLE:  if (player_req || simon_req) state_next = ST_HOLD;
        ST_HOLD:  if ((hold_num != num_reg) || (timer_done && !hold_req)) state_next = ST_GAP;
        ST_GAP:   if (timer_done) state_next = ST_IDLE;
        ST_ALARM: state_next = ST_GAP;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output values for the cycle after this edge, registered below
  always_comb begin
    num_next     = num_reg;
    pressed_next = 1'b0;
    owner_next   = OWN_NONE;
    case (state_next)
      ST_IDLE: num_next = 2'd0;
      ST_HOLD: begin
        pressed_next = 1'b1;
        if (state_reg == ST_HOLD) begin
          owner_next = owner_reg;
        end else if (player_req) begin
          owner_next = OWN_PLAYER;
          num_next   = player_num;
        end else begin
          owner_next = OWN_SIMON;
          num_next   = simon_num;
        end
      end
      ST_GAP: num_next = num_reg;
      ST_ALARM: begin
        pressed_next = 1'b1;
        owner_next   = OWN_ALARM;
        num_next     = alarm_num;
      end
      default: num_next = 2'd0;
    endcase
  end

  // Timer reload on every state entry and on every melody note boundary
  always_comb begin
    timer_load  = (state_next != state_reg) || note_adv;
    timer_value = '0;
    case (state_next)
      ST_HOLD:  timer_value = CNT_W'(MIN_HOLD_CYC);
      ST_GAP:   timer_value = CNT_W'(GAP_CYC);
      ST_ALARM: timer_value = CNT_W'(NOTE_CYC);
      default:  timer_value = '0;
    endcase
  end

  tone_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      num_reg     <= 2'd0;
      pressed_reg <= 1'b0;
      owner_reg   <= OWN_NONE;
    end else begin
      state_reg   <= state_next;
      num_reg     <= num_next;
      pressed_reg <= pressed_next;
      owner_reg   <= owner_next;
    end
  end

  assign num     = num_reg;
  assign pressed = pressed_reg;
  assign owner   = owner_reg;

endmodule

// File: tb/tb_feedback_arbiter.sv
// Bench for feedback_arbiter: dut0 uses hold=4/gap=2/note=3, dut1 uses 1/1/1.
module tb_feedback_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       simon_req = 1'b0;
  logic [1:0] simon_num = 2'd0;
  logic       player_req = 1'b0;
  logic [1:0] player_num = 2'd0;
  logic       game_over = 1'b0;
  logic [1:0] num0, owner0, num1, owner1;
  logic       pressed0, pressed1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  feedback_arbiter #(.MIN_HOLD_CYC(4), .GAP_CYC(2), .NOTE_CYC(3)) dut0 (
    .clk(clk), .reset(reset), .simon_req(simon_req), .simon_num(simon_num),
    .player_req(player_req), .player_num(player_num), .game_over(game_over),
    .num(num0), .pressed(pressed0), .owner(owner0)
  );

  feedback_arbiter #(.MIN_HOLD_CYC(1), .GAP_CYC(1), .NOTE_CYC(1)) dut1 (
    .clk(clk), .reset(reset), .simon_req(simon_req), .simon_num(simon_num),
    .player_req(player_req), .player_num(player_num), .game_over(game_over),
    .num(num1), .pressed(pressed1), .owner(owner1)
  );

  // Behavioural model: one set of variables per instance
  int p_hold[2] = '{4, 1};
  int p_gap[2]  = '{2, 1};
  int p_note[2] = '{3, 1};
  int m_owner[2], m_num[2], m_pressed[2], m_age[2], m_gap[2], m_note_idx[2], m_note_age[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_num[k] = 0; m_pressed[k] = 0; m_age[k] = 0;
      m_gap[k] = 0; m_note_idx[k] = 0; m_note_age[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently applied inputs
  task automatic model_step();
    int cur_req, cur_num;
    for (int k = 0; k < 2; k++) begin
      if (game_over) begin
        if (m_owner[k] != 3) begin
          m_owner[k] = 3; m_pressed[k] = 1; m_note_idx[k] = 0; m_note_age[k] = 1; m_gap[k] = 0;
        end else begin
          m_note_age[k]++;
          if (m_note_age[k] > p_note[k]) begin
            m_note_idx[k]++;
            m_note_age[k] = 1;
          end
        end
`ifdef ALARM_MELODY_EN
        m_num[k] = 3 - (m_note_idx[k] % 4);
`else
        m_num[k] = 3;
`endif
      end else if (m_owner[k] == 3) begin
        m_owner[k] = 0; m_pressed[k] = 0; m_gap[k] = p_gap[k];
      end else if (m_owner[k] != 0) begin
        cur_req = (m_owner[k] == 2) ? int'(player_req) : int'(simon_req);
        cur_num = (m_owner[k] == 2) ? int'(player_num) : int'(simon_num);
        if ((cur_num != m_num[k]) || (m_age[k] >= p_hold[k] && cur_req == 0)) begin
          m_owner[k] = 0; m_pressed[k] = 0; m_gap[k] = p_gap[k];
        end else begin
          m_age[k]++;
        end
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
        if (m_gap[k] == 0) m_num[k] = 0;
      end else if (player_req) begin
        m_owner[k] = 2; m_num[k] = int'(player_num); m_pressed[k] = 1; m_age[k] = 1;
      end else if (simon_req) begin
        m_owner[k] = 1; m_num[k] = int'(simon_num); m_pressed[k] = 1; m_age[k] = 1;
      end else begin
        m_num[k] = 0; m_pressed[k] = 0;
      end
    end
  endtask

  task automatic check_model();
    check("dut0_num",     int'(num0),     m_num[0]);
    check("dut0_pressed", int'(pressed0), m_pressed[0]);
    check("dut0_owner",   int'(owner0),   m_owner[0]);
    check("dut1_num",     int'(num1),     m_num[1]);
    check("dut1_pressed", int'(pressed1), m_pressed[1]);
    check("dut1_owner",   int'(owner1),   m_owner[1]);
  endtask

  // Apply inputs, clock once, step the model, compare on the falling edge
  task automatic cycle(input logic go, input logic pr, input logic [1:0] pn,
                       input logic sr, input logic [1:0] sn);
    game_over = go; player_req = pr; player_num = pn; simon_req = sr; simon_num = sn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic settle();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  typedef struct {
    logic       go;
    logic       pr;
    logic [1:0] pn;
    logic       sr;
    logic [1:0] sn;
    int         e_pressed;
    int         e_num;
    int         e_owner;
  } vec_t;

  vec_t vecs[21];
  int   exp_alarm[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Expected dut0 outputs after each edge for scenarios 1 and 2
    vecs[0]  = '{0, 1, 2, 0, 0, 1, 2, 2};
    vecs[1]  = '{0, 0, 2, 0, 0, 1, 2, 2};
    vecs[2]  = '{0, 0, 2, 0, 0, 1, 2, 2};
    vecs[3]  = '{0, 0, 2, 0, 0, 1, 2, 2};
    vecs[4]  = '{0, 0, 2, 0, 0, 0, 2, 0};
    vecs[5]  = '{0, 0, 2, 0, 0, 0, 2, 0};
    vecs[6]  = '{0, 0, 2, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 3, 1, 1, 1, 3, 2};
    vecs[8]  = '{0, 0, 3, 1, 1, 1, 3, 2};
    vecs[9]  = '{0, 0, 3, 1, 1, 1, 3, 2};
    vecs[10] = '{0, 0, 3, 1, 1, 1, 3, 2};
    vecs[11] = '{0, 0, 3, 1, 1, 0, 3, 0};
    vecs[12] = '{0, 0, 3, 1, 1, 0, 3, 0};
    vecs[13] = '{0, 0, 3, 1, 1, 0, 0, 0};
    vecs[14] = '{0, 0, 3, 1, 1, 1, 1, 1};
    vecs[15] = '{0, 0, 3, 0, 1, 1, 1, 1};
    vecs[16] = '{0, 0, 3, 0, 1, 1, 1, 1};
    vecs[17] = '{0, 0, 3, 0, 1, 1, 1, 1};
    vecs[18] = '{0, 0, 3, 0, 1, 0, 1, 0};
    vecs[19] = '{0, 0, 3, 0, 1, 0, 1, 0};
    vecs[20] = '{0, 0, 3, 0, 1, 0, 0, 0};
`ifdef ALARM_MELODY_EN
    exp_alarm = '{3, 3, 3, 2, 2, 2, 1};
`else
    exp_alarm = '{3, 3, 3, 3, 3, 3, 3};
`endif

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_num", int'(num0), 0);
    check("reset_pressed", int'(pressed0), 0);
    check("reset_owner", int'(owner0), 0);
    reset = 1'b0;
    $display("reset released at %0t", $time);

    // Scenarios 1 and 2 from the table
    for (int i = 0; i < 21; i++) begin
      cycle(vecs[i].go, vecs[i].pr, vecs[i].pn, vecs[i].sr, vecs[i].sn);
      check("vec_pressed", int'(pressed0), vecs[i].e_pressed);
      check("vec_num", int'(num0), vecs[i].e_num);
      check("vec_owner", int'(owner0), vecs[i].e_owner);
      $display("vec %0d: pressed=%0d num=%0d owner=%0d", i, pressed0, num0, owner0);
    end

    // Scenario 3: long hold, then the index changes mid-hold
    settle();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
      check("long_hold_pressed", int'(pressed0), 1);
    end
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    check("numchg_pressed", int'(pressed0), 0);
    check("numchg_owner", int'(owner0), 0);
    check("numchg_num", int'(num0), 1);
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    check("regrant_idle_pressed", int'(pressed0), 0);
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    check("regrant_pressed", int'(pressed0), 1);
    check("regrant_num", int'(num0), 0);
    $display("scenario 3: regrant num=%0d owner=%0d", num0, owner0);

    // Scenario 4: game_over during a hold
    settle();
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, 2'd2, 1'b0, 2'd0);
      check("alarm_owner", int'(owner0), 3);
      check("alarm_pressed", int'(pressed0), 1);
      check("alarm_num", int'(num0), exp_alarm[i]);
    end
    cycle(1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    check("alarm_end_owner", int'(owner0), 0);
    check("alarm_end_pressed", int'(pressed0), 0);
    $display("scenario 4: alarm ended owner=%0d", owner0);

    // Scenario 5: async reset mid-hold
    settle();
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    reset = 1'b1;
    #1;
    check("async_rst_pressed", int'(pressed0), 0);
    check("async_rst_owner", int'(owner0), 0);
    check("async_rst_num", int'(num0), 0);
    check("async_rst_pressed1", int'(pressed1), 0);
    model_reset();
    #2;
    reset = 1'b0;
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    check("post_rst_pressed", int'(pressed0), 1);
    check("post_rst_owner", int'(owner0), 2);
    $display("scenario 5: post-reset grant owner=%0d", owner0);

    // Scenario 6: one-cycle tone and gap on dut1
    settle();
    cycle(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
    check("min_tone_pressed", int'(pressed1), 1);
    check("min_tone_num", int'(num1), 3);
    cycle(1'b0, 1'b0, 2'd3, 1'b0, 2'd0);
    check("min_gap_pressed", int'(pressed1), 0);
    cycle(1'b0, 1'b0, 2'd3, 1'b0, 2'd0);
    check("min_idle_num", int'(num1), 0);
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    check("min_regrant_pressed", int'(pressed1), 1);
    check("min_regrant_num", int'(num1), 2);
    $display("scenario 6: dut1 regrant num=%0d", num1);

    // Randomized traffic against the model
    begin
      logic go, pr, sr;
      logic [1:0] pn, sn;
      go = 0; pr = 0; sr = 0; pn = 0; sn = 0;
      for (int i = 0; i < 2000; i++) begin
        if (go) begin
          if ($urandom_range(0, 7) == 0) go = 1'b0;
        end else if ($urandom_range(0, 59) == 0) begin
          go = 1'b1;
        end
        if ($urandom_range(0, 5) == 0) pr = ~pr;
        if ($urandom_range(0, 5) == 0) sr = ~sr;
        if ($urandom_range(0, 11) == 0) pn = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 11) == 0) sn = 2'($urandom_range(0, 3));
        cycle(go, pr, pn, sr, sn);
        if (i % 250 == 249) $display("random block %0d: checks=%0d", i / 250, checks);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
